// File: rtl/proc_pkg.sv
// Shared processor package: ALU op encodings, shift types, flag bit positions and datapath width.
package proc_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        OP_ADD_SUB     = 2'b00,
        OP_LOGICAL_AND = 2'b01,
        OP_SHFT_ROT    = 2'b10,
        OP_PASS        = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SHFT_LSL = 2'b00,
        SHFT_LSR = 2'b01,
        SHFT_ASR = 2'b10,
        SHFT_ROR = 2'b11
    } shft_e;

    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational 16-bit barrel shifter (LSL/LSR/ASR/ROR) returning the last bit shifted out as carry.
module barrel_shifter
    import proc_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    input  logic [3:0]        amt_i,
    input  logic [1:0]        type_i,
    output logic [DATA_W-1:0] result_o,
    output logic              cout_o
);

    // One guard bit on the far side of each shift captures the last bit shifted out.
    logic [DATA_W:0]        lsl_ext;
    logic [DATA_W:0]        lsr_ext;
    logic signed [DATA_W:0] asr_in;
    logic signed [DATA_W:0] asr_ext;
    logic [DATA_W-1:0]      ror_res;
    logic [4:0]             ror_back;

    assign lsl_ext  = {1'b0, data_i} << amt_i;
    assign lsr_ext  = {data_i, 1'b0} >> amt_i;
    assign asr_in   = {data_i, 1'b0};
    assign asr_ext  = asr_in >>> amt_i;
    assign ror_back = 5'd16 - {1'b0, amt_i};
    assign ror_res  = (data_i >> amt_i) | (data_i << ror_back);

    always_comb begin
        result_o = data_i;
        cout_o   = 1'b0;
        case (type_i)
            SHFT_LSL: begin
                result_o = lsl_ext[DATA_W-1:0];
                cout_o   = lsl_ext[DATA_W];
            end
            SHFT_LSR: begin
                result_o = lsr_ext[DATA_W:1];
                cout_o   = lsr_ext[0];
            end
            SHFT_ASR: begin
                result_o = asr_ext[DATA_W:1];
                cout_o   = asr_ext[0];
            end
            SHFT_ROR: begin
                result_o = ror_res;
                cout_o   = ror_res[DATA_W-1];
            end
            default: ;
        endcase
        if (amt_i == 4'd0) begin
            result_o = data_i;
            cout_o   = 1'b0;
        end
    end

endmodule

// File: rtl/alu_flag_unit.sv
// ALU with A/G/flags registers; shift/rotate support is compiled in only when ALU_SHIFT_ROT_EN is defined.
module alu_flag_unit
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              A_in,
    input  logic              G_in,
    input  logic              flag_in,
    input  logic [1:0]        op,
    input  logic              add_sub_ctrl,
    input  logic [1:0]        shift_rot_type,
    output logic [DATA_W-1:0] G_out,
    output logic [2:0]        flag_out
);

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] g_q, g_d;
    logic [2:0]        flag_q, flag_d;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_res;
    logic              alu_cout;

`ifdef ALU_SHIFT_ROT_EN
    logic [DATA_W-1:0] shft_res;
    logic              shft_cout;

    barrel_shifter u_shifter (
        .data_i   (a_q),
        .amt_i    (bus_in[3:0]),
        .type_i   (shift_rot_type),
        .result_o (shft_res),
        .cout_o   (shft_cout)
    );
`else
    logic unused_shift_type;
    assign unused_shift_type = ^shift_rot_type;
`endif

    // Subtract as A + ~B + 1 so the carry reads as "no borrow".
    always_comb begin
        if (add_sub_ctrl) begin
            sum = {1'b0, a_q} + {1'b0, ~bus_in} + 17'd1;
        end else begin
            sum = {1'b0, a_q} + {1'b0, bus_in};
        end
    end

    // Unknown or pass opcodes fall to the default: result = B, carry clear.
    always_comb begin
        alu_res  = bus_in;
        alu_cout = 1'b0;
        case (op)
            OP_ADD_SUB: begin
                alu_res  = sum[DATA_W-1:0];
                alu_cout = sum[DATA_W];
            end
            OP_LOGICAL_AND: begin
                alu_res = a_q & bus_in;
            end
`ifdef ALU_SHIFT_ROT_EN
            OP_SHFT_ROT: begin
                alu_res  = shft_res;
                alu_cout = shft_cout;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        a_d    = a_q;
        g_d    = g_q;
        flag_d = flag_q;
        if (!A_in) begin
            a_d = bus_in;
        end
        if (!G_in) begin
            g_d = alu_res;
        end
        if (!flag_in) begin
            flag_d[FLAG_C] = alu_cout;
            flag_d[FLAG_N] = alu_res[DATA_W-1];
            flag_d[FLAG_Z] = (alu_res == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q    <= '0;
            g_q    <= '0;
            flag_q <= '0;
        end else begin
            a_q    <= a_d;
            g_q    <= g_d;
            flag_q <= flag_d;
        end
    end

    assign G_out    = g_q;
    assign flag_out = flag_q;

endmodule

// File: doc/alu_flag_unit.md
ALU_FLAG_UNIT -- requirements
Module: alu_flag_unit

Interface
REQ-001 The reset shall be reset_n, synchronous, active-low, and the clock shall be clk.
REQ-002 Ports (name, direction, width, meaning) shall be:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- bus_in  in  16  processor bus; B operand
- A_in  in  1  active-low load enable, A register
- G_in  in  1  active-low load enable, G register
- flag_in  in  1  active-low load enable, flags register
- op  in  2  operation select (00 add/sub, 01 AND, 10 shift/rotate, 11 pass B)
- add_sub_ctrl  in  1  0 add, 1 subtract
- shift_rot_type  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- G_out  out  16  G register contents
- flag_out  out  3  {cout, n, z}

Function
REQ-003 The A register shall load bus_in on a clk edge where A_in=0, and hold otherwise.
REQ-004 The ALU shall be combinational on A (register) and B (bus_in), and its result shall be captured into G on a clk edge where G_in=0.
REQ-005 Add (op=00, add_sub_ctrl=0) shall compute the 17-bit sum A+B, with result bits [15:0] and cout = bit 16.
REQ-006 Subtract (op=00, add_sub_ctrl=1) shall compute A+~B+1 in 17 bits, with cout=1 meaning no borrow (A>=B unsigned).
REQ-007 AND (op=01) shall compute A&B with cout=0.
REQ-008 Shift/rotate (op=10) shall operate on A by amount B[3:0], as follows:
- LSL and LSR shift in zeros.
- ASR replicates A[15].
- ROR rotates right.
- cout shall be the last bit shifted out (for ROR, the bit rotated into bit 15).
- An amount of 0 shall give result=A and cout=0.
REQ-009 op=11 and any X/Z op shall give result=B and cout=0.
REQ-010 n shall equal result[15] and z shall equal (result==0), both computed from the ALU result, not from G.
REQ-011 The flags register shall load {cout,n,z} on a clk edge where flag_in=0, independent of G_in, so that a compare updates the flags without writing G.
REQ-012 When A_in=0 and G_in=0 on the same edge, the ALU shall use the pre-edge A value.
REQ-013 Latency shall be one cycle: G_out and flag_out shall reflect the operation on the edge after the enable, and shall be driven directly from registers with no combinational path from inputs.
REQ-014 An enable held low for N cycles shall reload each cycle.

Reset
REQ-015 On a clk edge with reset_n=0, A, G and flags shall be cleared to 0, so that G_out=16'h0000 and flag_out=3'b000.
REQ-016 Reset shall take priority over all load enables.
REQ-017 A reset mid-instruction shall discard any pending operation, and the first post-reset edge shall behave per REQ-003 to REQ-011.

Configuration
REQ-018 The macro ALU_SHIFT_ROT_EN shall compile in shift/rotate support: when defined, op=10 shall behave per REQ-008.
REQ-019 When ALU_SHIFT_ROT_EN is undefined, op=10 shall behave as op=11 (result=B, cout=0), shift_rot_type shall be ignored, and no shifter logic shall be synthesized.

Structure
REQ-020 The shared package proc_pkg shall hold:
- op encodings: OP_ADD_SUB, OP_LOGICAL_AND, OP_SHFT_ROT, OP_PASS
- shift types: SHFT_LSL, SHFT_LSR, SHFT_ASR, SHFT_ROR
- flag indices: FLAG_C=2, FLAG_N=1, FLAG_Z=0
- data width constant: 16
REQ-021 The shifter shall be a separate sub-module, barrel_shifter (16-bit data, 4-bit amount, 2-bit type, 16-bit result plus carry out), instantiated only under ALU_SHIFT_ROT_EN.

Verification
REQ-022 The bench shall cover at least these directed scenarios:
- Load A=16'h7FFF, add B=16'h0001 with G_in=0 and flag_in=0 -> G_out=16'h8000, flag_out=3'b010.
- Load A=16'h0005, sub B=16'h0005 with flag_in=0 and G_in=1 (compare) -> flag_out=3'b101, G_out unchanged.
- Load A=16'h0003, sub B=16'h0004 -> G_out=16'hFFFF, flag_out=3'b010 (borrow, so cout=0).
- Load A=16'h8001, run with B=16'h0001 and flag_in=0 (ALU_SHIFT_ROT_EN defined):
  - ASR -> G_out=16'hC000, cout=1.
  - ROR -> G_out=16'hC000, cout=1.
  - LSL -> G_out=16'h0002, cout=1.
- A_in=0 and G_in=0 on the same edge, with A=16'h0010, bus_in=16'h0001, add -> G_out=16'h0011, A=16'h0001.
- Assert reset_n=0 while G_in=0 and flag_in=0 -> G_out=0, flag_out=0. Then, with ALU_SHIFT_ROT_EN undefined, op=10 and bus_in=16'h1234 -> G_out=16'h1234, cout=0.
